// File: rtl/instr_loader_if.sv
// Byte-stream valid/ready channel feeding the instruction loader.
interface instr_loader_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;

  modport master (
    output byte_valid,
    output byte_data,
    input  byte_ready
  );

  modport slave (
    input  byte_valid,
    input  byte_data,
    output byte_ready
  );
endinterface

// File: rtl/instr_loader.sv
// Boot loader: assembles a byte stream into 32-bit words for instruction memory.
// Optional trailing checksum byte enabled by defining LOADER_CHECKSUM_EN.
module instr_loader #(
  parameter int PC_SIZE   = 10,
  parameter int WORD_STEP = 4,
  parameter int TIMEOUT   = 65535
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [PC_SIZE-1:0] load_len,
  instr_loader_if.slave      bytes,
  output logic               rw,
  output logic [PC_SIZE-1:0] PC_write,
  output logic [31:0]        instruction_in,
  output logic               reset_IF_memory,
  output logic               core_hold,
  output logic               busy,
  output logic               done,
  output logic               error
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RECV,
    S_WRITE,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE,
    S_ERROR
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t FIN = S_CHECK;
`else
  localparam state_t FIN = S_DONE;
`endif

  state_t             state;
  state_t             nxt;
  logic [PC_SIZE-1:0] len;
  logic [PC_SIZE-1:0] words;
  logic [PC_SIZE-1:0] pc;
  logic [1:0]         byte_idx;
  logic [31:0]        instr;
  logic [TW-1:0]      timer;
  logic               ready;
  logic               xfer;
  logic               tmo;
  logic               start_ok;
  logic               last_word;

  assign bytes.byte_ready = ready;
  assign PC_write         = pc;
  assign instruction_in   = instr;

  assign xfer      = bytes.byte_valid && ready;
  assign tmo       = !xfer && (timer == TW'(TIMEOUT - 1));
  assign last_word = (words + PC_SIZE'(1)) == len;
  assign start_ok  = start &&
                     (state == S_IDLE || state == S_DONE ||
                      state == S_ERROR);

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;

  always_ff @(posedge clock) begin
    if (!reset) begin
      csum <= '0;
    end else if (start_ok) begin
      csum <= '0;
    end else if (state == S_RECV && xfer) begin
      csum <= csum + bytes.byte_data;
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt             = state;
    ready           = 1'b0;
    rw              = 1'b0;
    reset_IF_memory = 1'b0;
    busy            = 1'b0;
    core_hold       = 1'b0;
    done            = 1'b0;
    error           = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) nxt = S_CLEAR;
      end
      S_CLEAR: begin
        reset_IF_memory = 1'b1;
        busy            = 1'b1;
        core_hold       = 1'b1;
        nxt = (len == '0) ? FIN : S_RECV;
      end
      S_RECV: begin
        ready     = 1'b1;
        busy      = 1'b1;
        core_hold = 1'b1;
        if (xfer && byte_idx == 2'd3) nxt = S_WRITE;
        else if (tmo)                 nxt = S_ERROR;
      end
      S_WRITE: begin
        rw        = 1'b1;
        busy      = 1'b1;
        core_hold = 1'b1;
        nxt = last_word ? FIN : S_RECV;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        ready     = 1'b1;
        busy      = 1'b1;
        core_hold = 1'b1;
        if (xfer) begin
          nxt = (bytes.byte_data == csum) ? S_DONE : S_ERROR;
        end else if (tmo) begin
          nxt = S_ERROR;
        end
      end
`endif
      S_DONE: begin
        done = 1'b1;
        nxt  = start ? S_CLEAR : S_IDLE;
      end
      S_ERROR: begin
        error     = 1'b1;
        core_hold = 1'b1;
        if (start) nxt = S_CLEAR;
      end
      default: nxt = S_IDLE;
    endcase
  end

  // timer restarts on entry to RECV/CHECK: start clears it, WRITE clears it
  always_ff @(posedge clock) begin
    if (!reset) begin
      len      <= '0;
      words    <= '0;
      pc       <= '0;
      byte_idx <= '0;
      instr    <= '0;
      timer    <= '0;
    end else begin
      if (start_ok) begin
        len      <= load_len;
        words    <= '0;
        pc       <= '0;
        byte_idx <= '0;
        timer    <= '0;
      end
      if (state == S_RECV) begin
        if (xfer) begin
          instr[8*byte_idx +: 8] <= bytes.byte_data;
          byte_idx <= byte_idx + 2'd1;
          timer    <= '0;
        end else begin
          timer <= timer + TW'(1);
        end
      end
`ifdef LOADER_CHECKSUM_EN
      if (state == S_CHECK && !xfer) begin
        timer <= timer + TW'(1);
      end
`endif
      if (state == S_WRITE) begin
        pc    <= pc + PC_SIZE'(WORD_STEP);
        words <= words + PC_SIZE'(1);
        timer <= '0;
      end
    end
  end

endmodule
